wfg_drive_pat: RTL and testbench

//  Parallel pattern driver: a second drive-stage sibling of wfg_drive_spi that consumes the stimulus
//  AXI-Stream and presents one sample per wfg_pat_sync_i pulse on CHANNELS parallel output pins.

---
 rtl/wfg_drive_pat.sv | 139 +++++++++++++
 tb/tb_wfg_drive_pat.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/wfg_drive_pat.sv
// Parallel pattern drive stage: one stream sample per sync pulse onto CHANNELS pins,
// each pin either stream-driven or held at a static register level.

module wfg_drive_pat_lane (
  input  logic mode,
  input  logic pat,
  input  logic stat,
  output logic dout
);
  assign dout = mode ? pat : stat;
endmodule

module wfg_drive_pat #(
  parameter int BUSW            = 32,
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int CHANNELS        = 16
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_ni,
  input  logic                       wbs_stb_i,
  input  logic                       wbs_cyc_i,
  input  logic                       wbs_we_i,
  input  logic [3:0]                 wbs_sel_i,
  input  logic [BUSW-1:0]            wbs_dat_i,
  input  logic [BUSW-1:0]            wbs_adr_i,
  output logic                       wbs_ack_o,
  output logic [BUSW-1:0]            wbs_dat_o,
  input  logic                       wfg_pat_sync_i,
  output logic                       wfg_axis_tready_o,
  input  logic                       wfg_axis_tvalid_i,
  input  logic [AXIS_DATA_WIDTH-1:0] wfg_axis_tdata_i,
  output logic [CHANNELS-1:0]        wfg_drive_pat_dout_o,
  output logic [CHANNELS-1:0]        wfg_drive_pat_oeb_o
);

  typedef enum logic [1:0] {S_DIS, S_PRIME, S_RUN} state_t;

  state_t              state, state_nxt;
  logic                en, wb_req, wb_wr;
  logic                wr_ctrl, wr_mode, wr_stat, wr_status, dis_req;
  logic                sync_apply, accept;
  logic                hold_valid, underrun;
  logic [CHANNELS-1:0] mode, stat, pat, hold;
  logic [BUSW-1:0]     rdata;
  logic                unused_ok;

  assign unused_ok = ^{wbs_sel_i, wbs_adr_i, wbs_dat_i, wfg_axis_tdata_i};

  // The request is masked while ack is high so a held strobe is acked every other cycle.
  assign wb_req     = wbs_stb_i && wbs_cyc_i && !wbs_ack_o;
  assign wb_wr      = wb_req && wbs_we_i;
  assign wr_ctrl    = wb_wr && (wbs_adr_i[3:2] == 2'd0);
  assign wr_mode    = wb_wr && (wbs_adr_i[3:2] == 2'd1);
  assign wr_stat    = wb_wr && (wbs_adr_i[3:2] == 2'd2);
  assign wr_status  = wb_wr && (wbs_adr_i[3:2] == 2'd3);
  assign dis_req    = wr_ctrl && !wbs_dat_i[0];
  assign sync_apply = wfg_pat_sync_i && hold_valid;
  assign accept     = wfg_axis_tvalid_i && wfg_axis_tready_o;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) state <= S_DIS;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_DIS:   if (wr_ctrl && wbs_dat_i[0]) state_nxt = S_PRIME;
      S_PRIME: if (sync_apply) state_nxt = S_RUN;
      default: ;
    endcase
    if (dis_req) state_nxt = S_DIS;
  end

  always_comb begin
    en                  = (state != S_DIS);
    wfg_axis_tready_o   = en && !hold_valid;
    wfg_drive_pat_oeb_o = {CHANNELS{~en}};
  end

  always_comb begin
    rdata = '0;
    case (wbs_adr_i[3:2])
      2'd0:    rdata[0] = en;
      2'd1:    rdata[CHANNELS-1:0] = mode;
      2'd2:    rdata[CHANNELS-1:0] = stat;
      default: rdata[1:0] = {hold_valid, underrun};
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      mode      <= '0;
      stat      <= '0;
    end else begin
      wbs_ack_o <= wb_req;
      wbs_dat_o <= wb_req ? rdata : '0;
      if (wr_mode) mode <= wbs_dat_i[CHANNELS-1:0];
      if (wr_stat) stat <= wbs_dat_i[CHANNELS-1:0];
    end
  end

  // Disable takes priority over both sync and handshake on the same edge.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      hold       <= '0;
      hold_valid <= 1'b0;
      pat        <= '0;
    end else if (state == S_DIS || dis_req) begin
      hold_valid <= 1'b0;
      pat        <= '0;
    end else if (sync_apply) begin
      pat        <= hold;
      hold_valid <= 1'b0;
    end else if (accept) begin
      hold       <= wfg_axis_tdata_i[CHANNELS-1:0];
      hold_valid <= 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni)
      underrun <= 1'b0;
    else if (state == S_RUN && wfg_pat_sync_i && !hold_valid && !dis_req)
      underrun <= 1'b1;
    else if (wr_status && wbs_dat_i[0])
      underrun <= 1'b0;
  end

  wfg_drive_pat_lane u_lane [CHANNELS-1:0] (
    .mode (mode),
    .pat  (pat),
    .stat (stat),
    .dout (wfg_drive_pat_dout_o)
  );

endmodule

// File: tb/tb_wfg_drive_pat.sv
// Bench for wfg_drive_pat: directed table, hand sequences for corner cases,
// and randomized sync/stream traffic against a queue-based reference model.

module tb_wfg_drive_pat;
  localparam int CH = 16;
  localparam logic [31:0] A_CTRL = 32'h0, A_MODE = 32'h4, A_STAT = 32'h8, A_STS = 32'hC;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          stb = 1'b0, cyc = 1'b0, we = 1'b0, sync = 1'b0, tvalid = 1'b0;
  logic [3:0]    sel = 4'hF;
  logic [31:0]   wdat = '0, adr = '0, tdata = '0, rdat;
  logic          ack, tready;
  logic [CH-1:0] dout, oeb;
  int            checks = 0, errors = 0;

  typedef struct {
    logic        sync;
    logic        tvalid;
    logic [31:0] tdata;
    logic [15:0] dout;
    logic        tready;
  } vec_t;
  vec_t tbl[8];

  always #5 clk = ~clk;

  wfg_drive_pat #(.BUSW(32), .AXIS_DATA_WIDTH(32), .CHANNELS(CH)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_dat_i(wdat), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .wfg_pat_sync_i(sync), .wfg_axis_tready_o(tready),
    .wfg_axis_tvalid_i(tvalid), .wfg_axis_tdata_i(tdata),
    .wfg_drive_pat_dout_o(dout), .wfg_drive_pat_oeb_o(oeb)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] q);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d;
    @(posedge clk); #1;
    chk("wb_ack", {31'b0, ack}, 32'd1);
    q = rdat;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    chk("wb_ack_single", {31'b0, ack}, 32'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] q;
    wb_xfer(1'b1, a, d, q);
  endtask

  task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] q;
    wb_xfer(1'b0, a, 32'h0, q);
    chk(nm, q, exp);
  endtask

  task automatic push(input logic [15:0] v);
    int n = 0;
    tvalid = 1'b1; tdata = {16'hDEAD, v};
    while (!tready && n < 20) begin @(posedge clk); #1; n++; end
    chk("push_tready", {31'b0, tready}, 32'd1);
    @(posedge clk); #1;
    tvalid = 1'b0;
  endtask

  task automatic pulse();
    sync = 1'b1;
    @(posedge clk); #1;
    sync = 1'b0;
  endtask

  initial begin
    logic [15:0] m, s, pat, acc_d;
    logic [15:0] q[$];
    logic        m_run, m_under, sy, tv, acc_ok;
    logic [31:0] dd;
    int          acc;

    tbl[0] = '{1'b1, 1'b0, 32'h0,        16'hFF00, 1'b1};
    tbl[1] = '{1'b0, 1'b1, 32'hAAAA0012, 16'hFF00, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 32'h000000AB, 16'hFF00, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 32'h0,        16'hFF12, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 32'h00000034, 16'hFF12, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 32'h0,        16'hFF34, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 32'h0000FFFF, 16'hFF34, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 32'h0,        16'hFFFF, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", {16'h0, dout}, 32'h0);
    chk("rst_oeb", {16'h0, oeb}, 32'hFFFF);
    chk("rst_tready", {31'b0, tready}, 32'h0);
    chk("rst_ack", {31'b0, ack}, 32'h0);
    chk("rst_dat", rdat, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd("rst_ctrl", A_CTRL, 32'h0);
    rd("rst_mode", A_MODE, 32'h0);
    rd("rst_static", A_STAT, 32'h0);
    rd("rst_status", A_STS, 32'h0);

    // Full stream mode, two samples
    wr(A_MODE, 32'hFFFF);
    wr(A_CTRL, 32'h1);
    chk("en_oeb", {16'h0, oeb}, 32'h0);
    chk("en_tready", {31'b0, tready}, 32'h1);
    rd("en_ctrl", A_CTRL, 32'h1);
    push(16'hA5A5);
    chk("stream_pre_sync", {16'h0, dout}, 32'h0);
    pulse();
    chk("stream_1", {16'h0, dout}, 32'hA5A5);
    push(16'h5A5A);
    pulse();
    chk("stream_2", {16'h0, dout}, 32'h5A5A);
    rd("stream_status", A_STS, 32'h0);

    // Mixed channels, table of per-cycle vectors starting from PRIME
    wr(A_CTRL, 32'h0);
    wr(A_MODE, 32'h00FF);
    wr(A_STAT, 32'hFF00);
    wr(A_CTRL, 32'h1);
    for (int i = 0; i < 8; i++) begin
      sync = tbl[i].sync; tvalid = tbl[i].tvalid; tdata = tbl[i].tdata;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_dout", i), {16'h0, dout}, {16'h0, tbl[i].dout});
      chk($sformatf("tbl%0d_tready", i), {31'b0, tready}, {31'b0, tbl[i].tready});
    end
    sync = 1'b0; tvalid = 1'b0;
    rd("tbl_status", A_STS, 32'h1);
    wr(A_STS, 32'h1);
    rd("w1c_status", A_STS, 32'h0);

    // Syncs in PRIME never flag underrun; set beats a coincident W1C
    wr(A_CTRL, 32'h0);
    wr(A_CTRL, 32'h1);
    pulse();
    pulse();
    rd("prime_no_underrun", A_STS, 32'h0);
    push(16'h1234);
    pulse();
    chk("prime_apply", {16'h0, dout}, 32'hFF34);
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = A_STS; wdat = 32'h1; sync = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0; cyc = 1'b0; we = 1'b0; sync = 1'b0;
    @(posedge clk); #1;
    chk("underrun_dout_held", {16'h0, dout}, 32'hFF34);
    rd("set_beats_w1c", A_STS, 32'h1);
    wr(A_STS, 32'h1);
    rd("w1c_again", A_STS, 32'h0);

    // Backpressure: one beat only until the next sync
    acc = 0; acc_d = '0;
    tvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tdata = 32'h100 * (i + 1) + 32'h0C;
      if (tready) begin acc++; if (acc == 1) acc_d = tdata[15:0]; end
      @(posedge clk); #1;
    end
    chk("bp_beats", acc, 32'd1);
    chk("bp_tready_low", {31'b0, tready}, 32'h0);
    tvalid = 1'b0;
    pulse();
    chk("bp_apply", {16'h0, dout}, {16'h0, (acc_d & 16'h00FF) | 16'hFF00});
    chk("bp_tready_back", {31'b0, tready}, 32'h1);

    // Disable with a sample held
    wr(A_MODE, 32'hFFFF);
    wr(A_STAT, 32'h0);
    push(16'h7E7E);
    rd("held_status", A_STS, 32'h2);
    wr(A_CTRL, 32'h0);
    chk("dis_dout", {16'h0, dout}, 32'h0);
    chk("dis_oeb", {16'h0, oeb}, 32'hFFFF);
    chk("dis_tready", {31'b0, tready}, 32'h0);
    rd("dis_status", A_STS, 32'h0);

    // Mid-run reset
    wr(A_CTRL, 32'h1);
    push(16'h1111);
    pulse();
    chk("pre_rst_dout", {16'h0, dout}, 32'h1111);
    push(16'h2222);
    tvalid = 1'b1; tdata = 32'h3333;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; tvalid = 1'b0;
    chk("mrst_dout", {16'h0, dout}, 32'h0);
    chk("mrst_oeb", {16'h0, oeb}, 32'hFFFF);
    chk("mrst_tready", {31'b0, tready}, 32'h0);
    rd("mrst_ctrl", A_CTRL, 32'h0);
    rd("mrst_mode", A_MODE, 32'h0);
    rd("mrst_status", A_STS, 32'h0);

    // Randomized traffic against a queue model
    m = 16'($urandom); s = 16'($urandom);
    wr(A_MODE, {16'h0, m});
    wr(A_STAT, {16'h0, s});
    wr(A_CTRL, 32'h1);
    pat = '0; m_run = 1'b0; m_under = 1'b0;
    for (int i = 0; i < 400; i++) begin
      sy = ($urandom_range(0, 2) == 0);
      tv = 1'($urandom_range(0, 1));
      dd = $urandom;
      sync = sy; tvalid = tv; tdata = dd;
      acc_ok = tv && (q.size() == 0);
      if (sy) begin
        if (q.size() != 0) begin pat = q.pop_front(); m_run = 1'b1; end
        else if (m_run) m_under = 1'b1;
      end
      if (acc_ok) q.push_back(dd[15:0]);
      @(posedge clk); #1;
      chk($sformatf("rnd%0d_dout", i), {16'h0, dout}, {16'h0, (m & pat) | (~m & s)});
      chk($sformatf("rnd%0d_tready", i), {31'b0, tready}, {31'b0, q.size() == 0});
    end
    sync = 1'b0; tvalid = 1'b0;
    rd("rnd_status", A_STS, {30'b0, q.size() != 0, m_under});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
